avmm_word_mem_slave: RTL

//  Avalon-MM pipelined slave (responder) holding a word-addressed on-chip memory. Serves
//  the SDRAM-facing master port of the copy/DNN accelerators. Read data comes back on

---
 rtl/avmm_mem_pkg.sv | 27 ++
 rtl/avmm_read_pipe.sv | 35 +++
 rtl/avmm_word_mem_slave.sv | 127 ++++++++++++
 3 files changed

// File: rtl/avmm_mem_pkg.sv
// Shared types, constants and byte-merge helper for the Avalon-MM word memory slave.
package avmm_mem_pkg;

  typedef enum logic {
    INIT  = 1'b0,
    READY = 1'b1
  } state_e;

  localparam int unsigned BYTE_OFS_W    = 2;
  localparam int unsigned WORD_W        = 32;
  localparam int unsigned BE_W          = WORD_W / 8;
  localparam logic [WORD_W-1:0] OOR_READ_DATA = 32'h0;

  function automatic logic [WORD_W-1:0] byte_merge(
    input logic [WORD_W-1:0] old_word,
    input logic [WORD_W-1:0] new_word,
    input logic [BE_W-1:0]   be
  );
    logic [WORD_W-1:0] res;
    res = old_word;
    for (int i = 0; i < int'(BE_W); i++) begin
      if (be[i]) res[8*i +: 8] = new_word[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/avmm_read_pipe.sv
// Fixed-latency read response pipeline: valid/data shift register, data holds when idle.
module avmm_read_pipe #(
  parameter int unsigned LATENCY = 2,
  parameter int unsigned DATA_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data
);

  logic [LATENCY-1:0] vld_q;
  logic [DATA_W-1:0]  dat_q [LATENCY];

  // Data stages only load behind a valid so the output word persists between pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q <= '0;
      for (int i = 0; i < int'(LATENCY); i++) dat_q[i] <= '0;
    end else begin
      vld_q[0] <= in_valid;
      if (in_valid) dat_q[0] <= in_data;
      for (int i = 1; i < int'(LATENCY); i++) begin
        vld_q[i] <= vld_q[i-1];
        if (vld_q[i-1]) dat_q[i] <= dat_q[i-1];
      end
    end
  end

  assign out_valid = vld_q[LATENCY-1];
  assign out_data  = dat_q[LATENCY-1];

endmodule

// File: rtl/avmm_word_mem_slave.sv
// Avalon-MM pipelined slave over a word-addressed RAM, self-clearing after reset.
// Optional stall injection: define AVMM_MEM_STALL_INJECT_EN.
module avmm_word_mem_slave
  import avmm_mem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS  = 1024,
  parameter int unsigned READ_LATENCY = 2,
  parameter int unsigned STALL_PERIOD = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [31:0]         slave_address,
  input  logic                slave_read,
  input  logic                slave_write,
  input  logic [WORD_W-1:0]   slave_writedata,
  input  logic [BE_W-1:0]     slave_byteenable,
  output logic                slave_waitrequest,
  output logic [WORD_W-1:0]   slave_readdata,
  output logic                slave_readdatavalid,
  output logic                init_done,
  output logic                proto_err,
  output logic                range_err
);

  localparam int unsigned IDX_W = 32 - BYTE_OFS_W;
  localparam int unsigned AW    = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  logic [WORD_W-1:0] mem [DEPTH_WORDS];

  state_e            state_q, state_nxt;
  logic [AW-1:0]     init_cnt_q;
  logic              init_last;
  logic [IDX_W-1:0]  word_idx;
  logic [AW-1:0]     ram_idx;
  logic              in_range;
  logic              accept;
  logic              wr_en;
  logic              rd_en;
  logic [WORD_W-1:0] rd_word;
  logic              stall_nxt;
  logic              unused_addr_lsb;

  assign unused_addr_lsb = ^slave_address[BYTE_OFS_W-1:0];

  // Address decode and acceptance; a combined read+write is served as a write only.
  assign word_idx  = slave_address[31:BYTE_OFS_W];
  assign ram_idx   = word_idx[AW-1:0];
  assign in_range  = word_idx < IDX_W'(DEPTH_WORDS);
  assign accept    = (slave_read | slave_write) & ~slave_waitrequest & (state_q == READY);
  assign wr_en     = accept & slave_write;
  assign rd_en     = accept & slave_read & ~slave_write;
  assign init_last = init_cnt_q == AW'(DEPTH_WORDS - 1);
  assign rd_word   = in_range ? mem[ram_idx] : OOR_READ_DATA;

  always_comb begin
    state_nxt = state_q;
    case (state_q)
      INIT:    if (init_last) state_nxt = READY;
      READY:   state_nxt = READY;
      default: state_nxt = INIT;
    endcase
  end

`ifdef AVMM_MEM_STALL_INJECT_EN
  localparam int unsigned SW = (STALL_PERIOD > 2) ? $clog2(STALL_PERIOD) : 1;

  logic [SW-1:0] stall_cnt_q, stall_cnt_nxt;

  // Free-running phase counter, restarting at 0 on the first READY cycle.
  always_comb begin
    stall_cnt_nxt = '0;
    if (state_q == READY) begin
      stall_cnt_nxt = (stall_cnt_q == SW'(STALL_PERIOD - 1)) ? '0 : stall_cnt_q + SW'(1);
    end
    stall_nxt = (state_nxt == READY) && (stall_cnt_nxt == SW'(STALL_PERIOD - 1));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) stall_cnt_q <= '0;
    else     stall_cnt_q <= stall_cnt_nxt;
  end
`else
  localparam int unsigned UNUSED_STALL_PERIOD = STALL_PERIOD;
  assign stall_nxt = 1'b0;
`endif

  // Control registers; waitrequest is precomputed so it never depends on the request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q           <= INIT;
      init_cnt_q        <= '0;
      slave_waitrequest <= 1'b1;
      init_done         <= 1'b0;
      proto_err         <= 1'b0;
      range_err         <= 1'b0;
    end else begin
      state_q           <= state_nxt;
      slave_waitrequest <= (state_nxt != READY) | stall_nxt;
      init_done         <= state_nxt == READY;
      if (state_q == INIT) init_cnt_q <= init_cnt_q + AW'(1);
      if (accept & slave_read & slave_write) proto_err <= 1'b1;
      if (accept & ~in_range)                range_err <= 1'b1;
    end
  end

  // RAM has no reset; the INIT sweep is the only clear path.
  always_ff @(posedge clk) begin
    if (state_q == INIT) begin
      mem[init_cnt_q] <= '0;
    end else if (wr_en && in_range) begin
      mem[ram_idx] <= byte_merge(mem[ram_idx], slave_writedata, slave_byteenable);
    end
  end

  avmm_read_pipe #(
    .LATENCY (READ_LATENCY),
    .DATA_W  (WORD_W)
  ) u_read_pipe (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (rd_en),
    .in_data   (rd_word),
    .out_valid (slave_readdatavalid),
    .out_data  (slave_readdata)
  );

endmodule
